prog_sequence_detector_fsm: RTL and testbench
=============================================

Name: prog_sequence_detector_fsm

Overview:
- Runtime-programmable serial bit-sequence detector. Generalises the team's fixed-pattern FSM detectors ("1010", "110011") to any pattern of length 1..MAX_LEN.
- Selectable overlapping or non-overlapping match mode, valid-qualified input, and a saturating match counter.
- Sits on a 1-bit serial stream; configured by a control block through a single-cycle write strobe.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (>=2)
CNT_W, 8, width of the match counter
DEFAULT_PATTERN, 8'b0000_1010, pattern loaded at reset (low DEFAULT_LEN bits used)
DEFAULT_LEN, 4, pattern length loaded at reset (1..MAX_LEN)
DEFAULT_OVERLAP, 1, overlap mode loaded at reset
LEN_W (derived, localparam), $clog2(MAX_LEN+1)

Ports:
clk  input  1  clock, all logic on posedge
rst  input  1  reset, synchronous, active-high
cfg_we  input  1  config write strobe
cfg_pattern  input  MAX_LEN  pattern; bit [len-1] is the first bit received, bit [0] the last
cfg_len  input  LEN_W  pattern length
cfg_overlap  input  1  1 = overlapping matches, 0 = restart after match
cfg_err  output  1  one-cycle pulse when a config write is rejected
in_valid  input  1  qualifies a
a  input  1  serial data bit
detected  output  1  one-cycle match pulse (registered)
match_count  output  CNT_W  saturating count of matches
progress  output  LEN_W  current FSM state (matched-prefix length), for debug

Behaviour:
- Reset (rst=1 at posedge):
  - pattern/len/overlap take the DEFAULT_* values.
  - progress=0, detected=0, match_count=0, cfg_err=0.
  - Reset overrides every other input, including mid-match and during cfg_we.
- FSM state is progress k, 0..len-1. A bit is accepted only on a posedge with in_valid=1. Cycles with in_valid=0 hold k, and detected goes 0.
- On an accepted bit b, let s = (first k pattern bits) followed by b:
  - If s equals the full pattern (k+1 == len): match. detected=1 on the next cycle for exactly one cycle. match_count increments, saturating at 2^CNT_W-1.
  - The next k after a match is: overlap=1, the length of the longest proper suffix of the pattern that is also a prefix of it (KMP failure value); overlap=0, k=0.
  - Otherwise, next k is the largest j <= k+1 such that the last j bits of s equal the first j pattern bits (0 if none).
- Fallback values are computed combinationally from the stored pattern (brute-force suffix/prefix compare over MAX_LEN). No precomputed table; pattern changes take effect without extra latency.
- len=1: every accepted bit equal to pattern[0] is a match in both modes; k stays 0.
- Latency: detected asserts 1 cycle after the posedge that accepts the final pattern bit.
- Config write (cfg_we=1):
  - cfg_len in 1..MAX_LEN: pattern/len/overlap are loaded and k=0. detected=0 and cfg_err=0 on the next cycle.
  - cfg_len=0 or >MAX_LEN: the write is rejected, the old config and k are kept, and cfg_err=1 for one cycle.
  - match_count is unaffected by config writes.
  - cfg_we and in_valid in the same cycle: config wins and the input bit is discarded, even if it would have completed a match.
- Pattern bits above len-1 are ignored.

Test Plan:
- Default config (1010, overlap). Stream 1,0,1,0,1,0,1,0 with in_valid=1 every cycle -> detected pulses after bits 4, 6 and 8; match_count=3.
- Write cfg_overlap=0, same pattern, same stream -> pulses after bits 4 and 8 only; count +2.
- Write pattern 6'b110011, len=6, overlap=1. Stream 1,1,0,0,1,1,0,0,1,1 -> pulses after bits 6 and 10 (failure value 2). Repeat with overlap=0 -> pulse after bit 6 only.
- Stream 1010 with in_valid=0 for 3 cycles between bits 2 and 3 -> single detected pulse after the 4th valid bit; progress holds 2 through the gap.
- cfg_we with cfg_len=0 -> cfg_err pulse, config unchanged. cfg_we with a valid config coincident with the final matching bit -> no detected pulse, progress=0.
- CNT_W=2, five matches -> match_count stops at 3. Assert rst after 3 matching bits -> progress=0 and count=0 next cycle, with no false detect.

Source files
------------

// File: rtl/prog_sequence_detector_fsm.sv
// Runtime-programmable serial bit-sequence detector with overlap/non-overlap modes,
// valid-qualified input and a saturating match counter.
module prog_sequence_detector_fsm #(
    parameter int                 MAX_LEN         = 8,
    parameter int                 CNT_W           = 8,
    parameter logic [MAX_LEN-1:0] DEFAULT_PATTERN = MAX_LEN'(8'b0000_1010),
    parameter int                 DEFAULT_LEN     = 4,
    parameter bit                 DEFAULT_OVERLAP = 1'b1,
    localparam int                LEN_W           = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_we,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    output logic               cfg_err,
    input  logic               in_valid,
    input  logic               a,
    output logic               detected,
    output logic [CNT_W-1:0]   match_count,
    output logic [LEN_W-1:0]   progress
);

    logic [MAX_LEN-1:0] pattern_q, pattern_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               overlap_q, overlap_d;
    logic [LEN_W-1:0]   prog_q, prog_d;
    logic               detected_q, detected_d;
    logic               cfg_err_q, cfg_err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [MAX_LEN-1:0] seq;        // pattern in arrival order: seq[0] is the first bit
    logic [LEN_W-1:0]   fb_len;
    logic               full_match;
    logic               cfg_ok;

    // Variable bit select as a constant-index mux; out-of-range reads give 0.
    function automatic logic bit_at(input logic [MAX_LEN-1:0] v, input int idx);
        logic r;
        r = 1'b0;
        for (int m = 0; m < MAX_LEN; m++) begin
            if (m == idx) r = v[m];
        end
        return r;
    endfunction

    always_comb begin
        seq = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (i < int'(len_q)) seq[i] = bit_at(pattern_q, int'(len_q) - 1 - i);
        end
    end

    // Longest proper border of (matched prefix + incoming bit). Capping j at len-1 makes
    // the same search yield the KMP failure value when the incoming bit completes the pattern.
    always_comb begin
        int  best;
        logic ok;
        best = 0;
        ok   = 1'b0;
        for (int j = 1; j <= MAX_LEN; j++) begin
            if (j <= int'(prog_q) + 1 && j <= int'(len_q) - 1) begin
                ok = (seq[j-1] == a);
                for (int t = 0; t < MAX_LEN - 1; t++) begin
                    if (t < j - 1 && bit_at(seq, int'(prog_q) + 1 - j + t) != seq[t]) ok = 1'b0;
                end
                if (ok) best = j;
            end
        end
        fb_len = LEN_W'(best);
    end

    assign full_match = (int'(prog_q) + 1 == int'(len_q)) && (bit_at(seq, int'(prog_q)) == a);
    assign cfg_ok     = (cfg_len != '0) && (int'(cfg_len) <= MAX_LEN);

    always_comb begin
        pattern_d  = pattern_q;
        len_d      = len_q;
        overlap_d  = overlap_q;
        prog_d     = prog_q;
        cnt_d      = cnt_q;
        detected_d = 1'b0;
        cfg_err_d  = 1'b0;
        if (cfg_we) begin
            // A config write always swallows a coincident input bit.
            if (cfg_ok) begin
                pattern_d = cfg_pattern;
                len_d     = cfg_len;
                overlap_d = cfg_overlap;
                prog_d    = '0;
            end else begin
                cfg_err_d = 1'b1;
            end
        end else if (in_valid) begin
            if (full_match) begin
                detected_d = 1'b1;
                if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
                prog_d = overlap_q ? fb_len : '0;
            end else begin
                prog_d = fb_len;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pattern_q  <= DEFAULT_PATTERN;
            len_q      <= LEN_W'(DEFAULT_LEN);
            overlap_q  <= DEFAULT_OVERLAP;
            prog_q     <= '0;
            cnt_q      <= '0;
            detected_q <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            pattern_q  <= pattern_d;
            len_q      <= len_d;
            overlap_q  <= overlap_d;
            prog_q     <= prog_d;
            cnt_q      <= cnt_d;
            detected_q <= detected_d;
            cfg_err_q  <= cfg_err_d;
        end
    end

    assign detected    = detected_q;
    assign cfg_err     = cfg_err_q;
    assign match_count = cnt_q;
    assign progress    = prog_q;

endmodule

// File: tb/tb_prog_sequence_detector_fsm.sv
// Directed bench for prog_sequence_detector_fsm; a second instance with CNT_W=2
// shares the stimulus to observe counter saturation.
module tb_prog_sequence_detector_fsm;

    logic       clk = 1'b0;
    logic       rst, cfg_we, cfg_overlap, in_valid, a;
    logic [7:0] cfg_pattern;
    logic [3:0] cfg_len;
    logic       cfg_err, detected;
    logic [7:0] match_count;
    logic [3:0] progress;
    logic       cfg_err2, detected2;
    logic [1:0] match_count2;
    logic [3:0] progress2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    prog_sequence_detector_fsm dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_err(cfg_err),
        .in_valid(in_valid), .a(a), .detected(detected),
        .match_count(match_count), .progress(progress)
    );

    prog_sequence_detector_fsm #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_err(cfg_err2),
        .in_valid(in_valid), .a(a), .detected(detected2),
        .match_count(match_count2), .progress(progress2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic send(input logic v, input logic b);
        in_valid = v;
        a        = b;
        @(posedge clk);
        #1;
        $display("tx valid=%0d a=%0d det=%0d k=%0d cnt=%0d", v, b, detected, progress, match_count);
    endtask

    // bits[n-1] is sent first; det_exp[n-1] is the detect expected after the first bit.
    task automatic stream(input string tag, input int n, input logic [15:0] bits,
                          input logic [15:0] det_exp);
        for (int i = 0; i < n; i++) begin
            send(1'b1, bits[n-1-i]);
            check($sformatf("%s_det%0d", tag, i + 1), {31'd0, detected}, {31'd0, det_exp[n-1-i]});
        end
        in_valid = 1'b0;
    endtask

    task automatic cfg_write(input string tag, input logic [7:0] pat, input logic [3:0] len,
                             input logic ov, input logic v, input logic b, input logic exp_err);
        cfg_we      = 1'b1;
        cfg_pattern = pat;
        cfg_len     = len;
        cfg_overlap = ov;
        in_valid    = v;
        a           = b;
        @(posedge clk);
        #1;
        $display("tx cfg pat=%b len=%0d ov=%0d err=%0d k=%0d", pat, len, ov, cfg_err, progress);
        cfg_we   = 1'b0;
        in_valid = 1'b0;
        check({tag, "_err"}, {31'd0, cfg_err}, {31'd0, exp_err});
        check({tag, "_det"}, {31'd0, detected}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; cfg_we = 1'b0; cfg_overlap = 1'b0; in_valid = 1'b0; a = 1'b0;
        cfg_pattern = '0; cfg_len = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_prog", progress, 0);
        check("rst_det", detected, 0);
        check("rst_cnt", match_count, 0);
        check("rst_err", cfg_err, 0);
        rst = 1'b0;

        // Default 1010, overlapping
        stream("ov1", 8, 16'b10101010, 16'b00010101);
        check("ov1_cnt", match_count, 3);
        check("ov1_prog", progress, 2);

        // Non-overlapping
        cfg_write("w_ov0", 8'b0000_1010, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0);
        check("w_ov0_prog", progress, 0);
        stream("ov0", 8, 16'b10101010, 16'b00010001);
        check("ov0_cnt", match_count, 5);
        check("sat_cnt", match_count2, 3);

        // 110011, failure value 2
        cfg_write("w_p6ov1", 8'b0011_0011, 4'd6, 1'b1, 1'b0, 1'b0, 1'b0);
        stream("p6ov1", 10, 16'b1100110011, 16'b0000010001);
        check("p6ov1_cnt", match_count, 7);
        cfg_write("w_p6ov0", 8'b0011_0011, 4'd6, 1'b0, 1'b0, 1'b0, 1'b0);
        stream("p6ov0", 10, 16'b1100110011, 16'b0000010000);
        check("p6ov0_cnt", match_count, 8);
        check("p6ov0_prog", progress, 2);

        // Invalid gap holds progress
        cfg_write("w_gap", 8'b0000_1010, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        send(1'b1, 1'b1);
        send(1'b1, 1'b0);
        check("gap_prog_pre", progress, 2);
        for (int i = 0; i < 3; i++) begin
            send(1'b0, 1'b1);
            check($sformatf("gap_prog%0d", i), progress, 2);
            check($sformatf("gap_det%0d", i), detected, 0);
        end
        send(1'b1, 1'b1);
        check("gap_det3", detected, 0);
        send(1'b1, 1'b0);
        check("gap_det4", detected, 1);
        check("gap_cnt", match_count, 9);

        // Rejected writes keep config and progress
        cfg_write("bad_len0", 8'hFF, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1);
        check("bad_len0_prog", progress, 2);
        send(1'b0, 1'b0);
        check("err_pulse_end", cfg_err, 0);
        stream("keep", 2, 16'b10, 16'b01);
        check("keep_cnt", match_count, 10);
        cfg_write("bad_len9", 8'hFF, 4'd9, 1'b0, 1'b0, 1'b0, 1'b1);
        check("bad_len9_prog", progress, 2);

        // Valid write coincident with the completing bit
        send(1'b1, 1'b1);
        check("pre_coinc_prog", progress, 3);
        cfg_write("coinc", 8'b0000_1010, 4'd4, 1'b1, 1'b1, 1'b0, 1'b0);
        check("coinc_prog", progress, 0);
        check("coinc_cnt", match_count, 10);
        send(1'b0, 1'b0);
        check("coinc_late_det", detected, 0);

        // Length-1 pattern
        cfg_write("w_len1", 8'b0000_0001, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        stream("len1", 4, 16'b1101, 16'b1101);
        check("len1_prog", progress, 0);
        check("len1_cnt", match_count, 13);
        check("len1_sat_cnt", match_count2, 3);

        // Reset mid-match
        cfg_write("w_rst", 8'b0000_1010, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        stream("pre_rst", 3, 16'b101, 16'b000);
        check("pre_rst_prog", progress, 3);
        rst = 1'b1; in_valid = 1'b1; a = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0; in_valid = 1'b0;
        check("mid_rst_prog", progress, 0);
        check("mid_rst_det", detected, 0);
        check("mid_rst_cnt", match_count, 0);
        check("mid_rst_sat_cnt", match_count2, 0);
        send(1'b0, 1'b0);
        check("post_rst_det", detected, 0);
        stream("post_rst", 4, 16'b1010, 16'b0001);
        check("post_rst_cnt", match_count, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
